// File: rtl/pwm_meter.sv
// rtl/pwm_meter.sv - PWM period / high-time / duty-cycle meter
//
// Measures an incoming PWM waveform. It reports the period and the high time
// in clk cycles, and the duty cycle in permille (0..1000). A restoring divider
// computes the duty cycle one quotient bit per cycle. A timeout flags an input
// that has stopped toggling.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   pwm_in     in   asynchronous PWM input
//   period     out  last measured period (clk cycles)
//   high_time  out  last measured high time (clk cycles)
//   duty       out  floor(high_time*1000/period); 0 or 1000 when stuck
//   valid      out  one-cycle pulse when period/high_time/duty update
//   stuck      out  level, no rising edge for TIMEOUT cycles
//   overrun    out  one-cycle pulse when a capture is dropped (divider busy)

module pwm_meter #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [9:0]       duty,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);

  localparam int NUM_W = CNT_W + 10;
  localparam int IT_W  = $clog2(NUM_W);
  localparam logic [IT_W-1:0]  IT_LAST = IT_W'(NUM_W - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_PRE  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic             armed_q, armed_d;
  state_t           state_q, state_d;
  logic [IT_W-1:0]  it_q, it_d;
  logic [CNT_W-1:0] den_q, den_d, hi_lat_q, hi_lat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] period_q, period_d, high_time_q, high_time_d;
  logic [9:0]       duty_q, duty_d;
  logic             valid_q, valid_d, stuck_q, stuck_d, overrun_q, overrun_d;

  logic             rise, timeout;
  logic [CNT_W:0]   trial, sub;
  logic             ge;
  logic [NUM_W-1:0] quo_next;

  always_comb begin
    s1_d        = pwm_in;
    s2_d        = s1_q;
    s3_d        = s2_q;
    per_cnt_d   = per_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    armed_d     = armed_q;
    state_d     = state_q;
    it_d        = it_q;
    den_d       = den_q;
    hi_lat_d    = hi_lat_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    overrun_d   = 1'b0;

    rise    = s2_q & ~s3_q;
    // One-shot: fires only on the step to TIMEOUT, after which per_cnt holds.
    timeout = ~rise && (per_cnt_q == TO_PRE);

    // The remainder stays below the denominator, so the shifted trial fits
    // in CNT_W+1 bits and the restored remainder fits back into CNT_W.
    trial    = {rem_q, quo_q[NUM_W-1]};
    sub      = trial - {1'b0, den_q};
    ge       = (trial >= {1'b0, den_q});
    quo_next = {quo_q[NUM_W-2:0], ge};

    if (rise) begin
      per_cnt_d = CNT_W'(1);
      hi_cnt_d  = CNT_W'(1);
    end else begin
      if (per_cnt_q != TO_VAL) per_cnt_d = per_cnt_q + CNT_W'(1);
      hi_cnt_d = hi_cnt_q + {{(CNT_W-1){1'b0}}, s2_q};
    end

    case (state_q)
      S_IDLE: ;
      S_DIV: begin
        rem_d = ge ? sub[CNT_W-1:0] : trial[CNT_W-1:0];
        quo_d = quo_next;
        it_d  = it_q + IT_W'(1);
        if (it_q == IT_LAST) begin
          state_d     = S_DONE;
          period_d    = den_q;
          high_time_d = hi_lat_q;
          duty_d      = quo_next[9:0];
          valid_d     = 1'b1;
          stuck_d     = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A rise while the divider sits in DONE is accepted: DONE only lasts one
    // cycle and the results are already in the output registers.
    if (rise) begin
      armed_d = 1'b1;
      if (armed_q) begin
        if (state_q == S_DIV) begin
          overrun_d = 1'b1;
        end else begin
          state_d  = S_DIV;
          it_d     = '0;
          den_d    = per_cnt_q;
          hi_lat_d = hi_cnt_q;
          rem_d    = '0;
          quo_d    = NUM_W'(hi_cnt_q) * NUM_W'(1000);
        end
      end
    end

    if (timeout) begin
      stuck_d     = 1'b1;
      armed_d     = 1'b0;
      period_d    = '0;
      high_time_d = '0;
      duty_d      = s2_q ? 10'd1000 : 10'd0;
      valid_d     = 1'b1;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= S_IDLE;
      it_q        <= '0;
      den_q       <= '0;
      hi_lat_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      it_q        <= it_d;
      den_q       <= den_d;
      hi_lat_q    <= hi_lat_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      overrun_q   <= overrun_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign duty      = duty_q;
  assign valid     = valid_q;
  assign stuck     = stuck_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pwm_meter.sv
// tb/tb_pwm_meter.sv - directed self-checking bench for pwm_meter

module tb_pwm_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [11:0] period;
  logic [11:0] high_time;
  logic [9:0]  duty;
  logic        valid;
  logic        stuck;
  logic        overrun;

  pwm_meter #(.CNT_W(12), .TIMEOUT(4000)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .duty      (duty),
    .valid     (valid),
    .stuck     (stuck),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int per;
    int hi;
    int dt;
    int stk;
  } rec_t;

  rec_t recs [0:255];
  int   nv     = 0;
  int   ov_cnt = 0;

  always @(negedge clk) begin
    if (valid && nv < 256) begin
      recs[nv] <= '{cyc, int'(period), int'(high_time), int'(duty), int'(stuck)};
      nv <= nv + 1;
    end
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  int total = 0;
  int bad   = 0;
  int rd    = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      repeat (hi) tick();
      pwm_in = 1'b0;
      repeat (per - hi) tick();
    end
  endtask

  task automatic exp_rec(input string tag, input int ec, input int eper,
                         input int ehi, input int edt, input int estk);
    rec_t r;
    chk({tag, ".have"}, int'(rd < nv), 1);
    if (rd < nv) begin
      r = recs[rd];
      rd++;
      chk({tag, ".cyc"}, r.c, ec);
      chk({tag, ".period"}, r.per, eper);
      chk({tag, ".high"}, r.hi, ehi);
      chk({tag, ".duty"}, r.dt, edt);
      chk({tag, ".stuck"}, r.stk, estk);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".period"}, int'(period), 0);
    chk({tag, ".high"}, int'(high_time), 0);
    chk({tag, ".duty"}, int'(duty), 0);
    chk({tag, ".valid"}, int'(valid), 0);
    chk({tag, ".stuck"}, int'(stuck), 0);
    chk({tag, ".overrun"}, int'(overrun), 0);
  endtask

  // pwm_in set in cycle n gives the rise cycle n+2 and valid in n+25.
  initial begin
    int c, e, q, ov0;
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (4) tick();
    check_zero("rst");
    rst = 1'b0;
    repeat (5) tick();

    // 1000/500: first rise only arms, then one valid per period
    c = cyc; rd = nv; ov0 = ov_cnt;
    wave(1000, 500, 3);
    chk("b.cnt", nv - rd, 2);
    exp_rec("b1", c + 1025, 1000, 500, 500, 0);
    exp_rec("b2", c + 2025, 1000, 500, 500, 0);
    chk("b.ovr", ov_cnt - ov0, 0);

    c = cyc; rd = nv;
    wave(999, 333, 2);
    chk("c.cnt", nv - rd, 2);
    exp_rec("c0", c + 25, 1000, 500, 500, 0);
    exp_rec("c1", c + 1024, 999, 333, 333, 0);

    c = cyc; rd = nv;
    wave(1000, 1, 2);
    chk("d.cnt", nv - rd, 2);
    exp_rec("d0", c + 25, 999, 333, 333, 0);
    exp_rec("d1", c + 1025, 1000, 1, 1, 0);

    c = cyc; rd = nv;
    wave(1000, 999, 2);
    chk("e.cnt", nv - rd, 2);
    exp_rec("e0", c + 25, 1000, 1, 1, 0);
    exp_rec("e1", c + 1025, 1000, 999, 999, 0);

    // abrupt duty change 200 -> 700
    c = cyc; rd = nv;
    wave(1000, 200, 2);
    exp_rec("f0", c + 25, 1000, 999, 999, 0);
    exp_rec("f1", c + 1025, 1000, 200, 200, 0);
    c = cyc; rd = nv;
    wave(1000, 700, 3);
    chk("f.cnt", nv - rd, 3);
    exp_rec("f2", c + 25, 1000, 200, 200, 0);
    exp_rec("f3", c + 1025, 1000, 700, 700, 0);
    exp_rec("f4", c + 2025, 1000, 700, 700, 0);

    // held high: timeout 4000 cycles after the rise cycle
    c = cyc; rd = nv;
    pwm_in = 1'b1;
    repeat (4100) tick();
    chk("g.cnt", nv - rd, 2);
    exp_rec("g0", c + 25, 1000, 700, 700, 0);
    exp_rec("g1", c + 4002, 0, 0, 1000, 1);
    chk("g.stuck", int'(stuck), 1);
    pwm_in = 1'b0;
    repeat (10) tick();
    c = cyc; rd = nv;
    wave(1000, 500, 2);
    chk("g.recov.cnt", nv - rd, 1);
    exp_rec("g2", c + 1025, 1000, 500, 500, 0);

    // period shorter than the divider: alternate rises overrun
    c = cyc; rd = nv; ov0 = ov_cnt;
    wave(20, 10, 10);
    chk("h.cnt", nv - rd, 5);
    exp_rec("h0", c + 25, 1000, 500, 500, 0);
    for (int k = 1; k <= 4; k++) exp_rec("h", c + 40 * k + 25, 20, 10, 500, 0);
    chk("h.ovr", ov_cnt - ov0, 5);

    // reset five cycles into a divide
    c = cyc; rd = nv;
    pwm_in = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check_zero("i");
    e = cyc;
    rst = 1'b0;
    repeat (50) tick();
    chk("i.nov", nv - rd, 0);
    pwm_in = 1'b0;
    repeat (50) tick();
    q = cyc;
    pwm_in = 1'b1;
    repeat (40) tick();
    chk("i.cnt", nv - rd, 1);
    exp_rec("i0", q + 25, q - e, 50, 500, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
